usart_bus_master: RTL
=====================

# usart_bus_master

Hardware sequencer that drives the USARTn data-bus register interface as a bus initiator, replacing CPU firmware for bring-up and loopback regression. It programs baud and frame registers, then polls UCSRnA and moves bytes between stream handshakes and UDRn. It sits on the `ram_Addr`/`ramre`/`ramwe` bus in place of the core's data-memory controller.

## Interface

**Parameters**

- `BASE`, default 12'h0C0: UCSRnA address. Derived addresses:
  - UCSRnB = BASE+1
  - UCSRnC = BASE+2
  - UBRRnL = BASE+4
  - UBRRnH = BASE+5
  - UDRn = BASE+6
- `GAP`, default 1: idle bus cycles inserted after every access, range 0..15.

**Ports**

- `cp2` in 1: system clock. All logic updates on the rising edge.
- `ireset` in 1: reset, asynchronous, active-high.
- `start` in 1: one-cycle pulse that begins initialisation. Ignored unless the FSM is in IDLE.
- `cfg_ubrr` in 12: baud divisor. Sampled on `start`.
- `cfg_ucsrc` in 8: UCSRnC value. Sampled on `start`.
- `cfg_u2x` in 1: UCSRnA.U2X value. Sampled on `start`.
- `tx_valid` in 1, `tx_data` in 8, `tx_ready` out 1: transmit byte stream.
- `rx_valid` out 1, `rx_data` out 8, `rx_ready` in 1: receive byte stream.
- `rx_err` out 3: sticky {FE, DOR, UPE} captured from UCSRnA[4:2].
- `init_done` out 1: high once the FSM is in RUN.
- `ram_Addr` out 12: bus address.
- `ramre` out 1, `ramwe` out 1: read / write strobes.
- `dbus_out` out 8: write data to the USART `dbus_in`.
- `dbus_in` in 8: read data from the USART `dbus_out`.

## Operation

**FSM states:** IDLE, W_UBRRH, W_UBRRL, W_A, W_B, W_C, POLL, RD_UDR, WR_UDR, GAP.

**Initialisation** (entered from IDLE on `start`)

- Five writes in this fixed order:
  1. UBRRnH = {4'b0, ubrr[11:8]}
  2. UBRRnL = ubrr[7:0]
  3. UCSRnA = {6'b0, u2x, 1'b0}
  4. UCSRnB = 8'b0001_1000 (RXEN, TXEN)
  5. UCSRnC = cfg_ucsrc
- After the UCSRnC write, the FSM enters RUN, which is the POLL/RD_UDR/WR_UDR loop.

**Bus access**

- Exactly one strobe per access, high for one cycle.
- `ramre` and `ramwe` are never high together.
- `ram_Addr` and `dbus_out` are valid while the strobe is high.
- Read data is sampled from `dbus_in` on the same rising edge that ends the `ramre` cycle.
- Every access is followed by GAP idle cycles with both strobes low. `ram_Addr` holds its last value during the gap.

**POLL**

- Read UCSRnA.
- If RXC=1 and `rx_valid`=0: latch the error bits into the captured set, go to RD_UDR.
- Else if UDRE=1 and `tx_valid`=1: go to WR_UDR.
- Else: go to POLL again after the gap.
- RX has priority over TX.

**RD_UDR**

- Read UDRn.
- Load `rx_data`, set `rx_valid`.
- OR the captured error bits into `rx_err`.

**WR_UDR**

- Write `tx_data` to UDRn.
- `tx_ready` is high for exactly this cycle; the handshake completes when `tx_valid` && `tx_ready`.
- `tx_data` must be stable from the POLL decision until this cycle.

**RX output**

- One-entry holding register.
- `rx_valid` clears on the edge where `rx_valid` && `rx_ready`.
- While `rx_valid`=1, RXC is not serviced, so the USART buffers or overruns; DOR then appears in `rx_err`.

**Error flag:** `rx_err` is sticky and cleared only by reset or `start`.

**Restart:** `start` in RUN is ignored. Re-initialisation requires reset.

## Timing

**Reset values**

- Outputs 0: `ram_Addr`, `dbus_out`, `ramre`, `ramwe`, `tx_ready`, `rx_valid`, `rx_data`, `rx_err`, `init_done`.
- FSM state: IDLE.

**Latencies**

- First write strobe: the cycle after the `start` edge.
- Init with GAP=1: 10 cycles from the first strobe to the end of the last gap. `init_done` rises on the edge that enters the first POLL.
- Minimum service time:
  - RX byte: POLL + gap + RD_UDR + gap = 4 cycles (GAP=1).
  - TX byte: 4 cycles by the same count.

**Boundary behaviour**

- RXC and UDRE both set with `tx_valid`: RX is read first; TX is taken on the next POLL.
- `rx_ready` held low: TX continues to be serviced.
- `tx_valid` dropped after the POLL decision: the write still occurs with the registered byte. `tx_data` is registered at the POLL decision.
- `ireset` mid-access: strobes drop asynchronously; no partial write is retried.

## Structure

- Package `usart_pkg`:
  - register offsets (A=0, B=1, C=2, UBRRL=4, UBRRH=5, UDR=6)
  - UCSRnA bit indices (RXC 7, TXC 6, UDRE 5, FE 4, DOR 3, UPE 2, U2X 1)
  - UCSRnB bit indices (RXEN 4, TXEN 3)
  - FSM state enum
- Single module. The gap counter is inline; no sub-module is needed.

## Test plan

- **Init:** reset, then `start` with ubrr=12'h081, ucsrc=8'h06, u2x=0. Expect exactly five writes: C5←00, C4←81, C0←00, C1←18, C2←06. Each strobe is one cycle with a one-cycle gap. `init_done` rises afterwards.
- **TX:** the USART model reports UDRE=1. `tx_data`=8'h65 with `tx_valid` produces a C6←65 write. `tx_ready` pulses exactly once.
- **RX priority:** status 8'hA0 (RXC+UDRE) with `tx_valid` high. Expect read of C6 first, then a C6 write on the next POLL. `rx_data` = model byte 8'h55.
- **Backpressure/error:** `rx_ready`=0 with a second RXC pending. C6 is not read. Status 8'h88 after release gives `rx_err`=3'b010, which persists until `start` or reset.
- **Reset mid-op:** assert `ireset` during `ramwe`. Strobes fall immediately, all outputs return to 0, and the FSM is in IDLE.
- **Loopback:** connect to USARTn with TxD tied to RxD. Send 8'h65 then 8'h55. Expect `rx_data` 8'h65 then 8'h55 with `rx_err`=0.

Source files
------------

// File: rtl/usart_bus_master_pkg.sv
// Shared types and constants for the USARTn bus-master sequencer.
package usart_pkg;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned GAP_W  = 4;

  // Register offsets relative to UCSRnA
  typedef enum logic [2:0] {
    OFS_A     = 3'd0,
    OFS_B     = 3'd1,
    OFS_C     = 3'd2,
    OFS_UBRRL = 3'd4,
    OFS_UBRRH = 3'd5,
    OFS_UDR   = 3'd6
  } reg_ofs_e;

  typedef enum logic [2:0] {
    BIT_RXC  = 3'd7,
    BIT_TXC  = 3'd6,
    BIT_UDRE = 3'd5,
    BIT_FE   = 3'd4,
    BIT_DOR  = 3'd3,
    BIT_UPE  = 3'd2,
    BIT_U2X  = 3'd1
  } ucsra_bit_e;

  typedef enum logic [2:0] {
    BIT_RXEN = 3'd4,
    BIT_TXEN = 3'd3
  } ucsrb_bit_e;

  localparam logic [DATA_W-1:0] UCSRB_INIT = 8'b0001_1000;

  typedef enum logic [3:0] {
    S_IDLE,
    S_W_UBRRH,
    S_W_UBRRL,
    S_W_A,
    S_W_B,
    S_W_C,
    S_POLL,
    S_RD_UDR,
    S_WR_UDR,
    S_GAP
  } state_e;

endpackage

// File: rtl/usart_bus_master_if.sv
// Data-bus and byte-stream bundle between the sequencer and its environment.
interface usart_bus_master_if;
  import usart_pkg::*;

  logic [ADDR_W-1:0] ram_Addr;
  logic              ramre;
  logic              ramwe;
  logic [DATA_W-1:0] dbus_out;
  logic [DATA_W-1:0] dbus_in;
  logic              tx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_ready;
  logic              rx_valid;
  logic [DATA_W-1:0] rx_data;
  logic              rx_ready;

  modport master (
    output ram_Addr, ramre, ramwe, dbus_out, tx_ready, rx_valid, rx_data,
    input  dbus_in, tx_valid, tx_data, rx_ready
  );

  modport slave (
    input  ram_Addr, ramre, ramwe, dbus_out, tx_ready, rx_valid, rx_data,
    output dbus_in, tx_valid, tx_data, rx_ready
  );

endinterface

// File: rtl/usart_bus_master.sv
// Bus initiator that programs USARTn, then polls UCSRnA and moves bytes
// between the tx/rx streams and UDRn.
module usart_bus_master
  import usart_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE = 12'h0C0,
  parameter int unsigned       GAP  = 1
) (
  input  logic                cp2,
  input  logic                ireset,
  input  logic                start,
  input  logic [11:0]         cfg_ubrr,
  input  logic [DATA_W-1:0]   cfg_ucsrc,
  input  logic                cfg_u2x,
  output logic [2:0]          rx_err,
  output logic                init_done,
  usart_bus_master_if.master  bus
);

  state_e            state_q, state_d, ret_q, ret_d, follow;
  logic              acc_end;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [11:0]       ubrr_q, ubrr_d;
  logic [DATA_W-1:0] ucsrc_q, ucsrc_d;
  logic              u2x_q, u2x_d;
  logic [DATA_W-1:0] tx_byte_q, tx_byte_d;
  logic [2:0]        err_cap_q, err_cap_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic [2:0]        rx_err_q, rx_err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              re_q, re_d, we_q, we_d;
  logic              tx_ready_q, tx_ready_d;
  logic              init_done_q, init_done_d;

  always_ff @(posedge cp2 or posedge ireset) begin
    if (ireset) begin
      state_q     <= S_IDLE;
      ret_q       <= S_IDLE;
      gap_cnt_q   <= '0;
      ubrr_q      <= '0;
      ucsrc_q     <= '0;
      u2x_q       <= 1'b0;
      tx_byte_q   <= '0;
      err_cap_q   <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      rx_err_q    <= '0;
      addr_q      <= '0;
      dout_q      <= '0;
      re_q        <= 1'b0;
      we_q        <= 1'b0;
      tx_ready_q  <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      gap_cnt_q   <= gap_cnt_d;
      ubrr_q      <= ubrr_d;
      ucsrc_q     <= ucsrc_d;
      u2x_q       <= u2x_d;
      tx_byte_q   <= tx_byte_d;
      err_cap_q   <= err_cap_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      rx_err_q    <= rx_err_d;
      addr_q      <= addr_d;
      dout_q      <= dout_d;
      re_q        <= re_d;
      we_q        <= we_d;
      tx_ready_q  <= tx_ready_d;
      init_done_q <= init_done_d;
    end
  end

  // Next state; every access state funnels through the gap counter
  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    gap_cnt_d  = gap_cnt_q;
    ubrr_d     = ubrr_q;
    ucsrc_d    = ucsrc_q;
    u2x_d      = u2x_q;
    tx_byte_d  = tx_byte_q;
    err_cap_d  = err_cap_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    rx_err_d   = rx_err_q;
    follow     = S_IDLE;
    acc_end    = 1'b0;

    if (rx_valid_q && bus.rx_ready) rx_valid_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_W_UBRRH;
          ubrr_d   = cfg_ubrr;
          ucsrc_d  = cfg_ucsrc;
          u2x_d    = cfg_u2x;
          rx_err_d = '0;
        end
      end
      S_W_UBRRH: begin acc_end = 1'b1; follow = S_W_UBRRL; end
      S_W_UBRRL: begin acc_end = 1'b1; follow = S_W_A;     end
      S_W_A:     begin acc_end = 1'b1; follow = S_W_B;     end
      S_W_B:     begin acc_end = 1'b1; follow = S_W_C;     end
      S_W_C:     begin acc_end = 1'b1; follow = S_POLL;    end
      S_POLL: begin
        acc_end = 1'b1;
        follow  = S_POLL;
        // A held rx byte blocks RXC service so the USART itself flags overrun
        if (bus.dbus_in[BIT_RXC] && !rx_valid_q) begin
          follow    = S_RD_UDR;
          err_cap_d = bus.dbus_in[BIT_FE:BIT_UPE];
        end else if (bus.dbus_in[BIT_UDRE] && bus.tx_valid) begin
          follow    = S_WR_UDR;
          tx_byte_d = bus.tx_data;
        end
      end
      S_RD_UDR: begin
        acc_end    = 1'b1;
        follow     = S_POLL;
        rx_data_d  = bus.dbus_in;
        rx_valid_d = 1'b1;
        rx_err_d   = rx_err_q | err_cap_q;
      end
      S_WR_UDR: begin acc_end = 1'b1; follow = S_POLL; end
      S_GAP: begin
        if (gap_cnt_q == '0) state_d = ret_q;
        else                 gap_cnt_d = gap_cnt_q - GAP_W'(1);
      end
      default: state_d = S_IDLE;
    endcase

    if (acc_end) begin
      if (GAP == 0) begin
        state_d = follow;
      end else begin
        state_d   = S_GAP;
        ret_d     = follow;
        gap_cnt_d = GAP_W'(GAP - 1);
      end
    end
  end

  // Registered bus outputs, decoded from the state being entered
  always_comb begin
    addr_d      = addr_q;
    dout_d      = dout_q;
    re_d        = 1'b0;
    we_d        = 1'b0;
    tx_ready_d  = 1'b0;
    init_done_d = init_done_q | (state_d == S_POLL);

    unique case (state_d)
      S_W_UBRRH: begin
        we_d = 1'b1; addr_d = BASE + ADDR_W'(OFS_UBRRH); dout_d = {4'b0000, ubrr_d[11:8]};
      end
      S_W_UBRRL: begin
        we_d = 1'b1; addr_d = BASE + ADDR_W'(OFS_UBRRL); dout_d = ubrr_d[7:0];
      end
      S_W_A: begin
        we_d = 1'b1; addr_d = BASE + ADDR_W'(OFS_A); dout_d = {6'b000000, u2x_d, 1'b0};
      end
      S_W_B: begin
        we_d = 1'b1; addr_d = BASE + ADDR_W'(OFS_B); dout_d = UCSRB_INIT;
      end
      S_W_C: begin
        we_d = 1'b1; addr_d = BASE + ADDR_W'(OFS_C); dout_d = ucsrc_d;
      end
      S_POLL: begin
        re_d = 1'b1; addr_d = BASE + ADDR_W'(OFS_A);
      end
      S_RD_UDR: begin
        re_d = 1'b1; addr_d = BASE + ADDR_W'(OFS_UDR);
      end
      S_WR_UDR: begin
        we_d = 1'b1; tx_ready_d = 1'b1; addr_d = BASE + ADDR_W'(OFS_UDR); dout_d = tx_byte_d;
      end
      default: ;
    endcase
  end

  assign bus.ram_Addr = addr_q;
  assign bus.ramre    = re_q;
  assign bus.ramwe    = we_q;
  assign bus.dbus_out = dout_q;
  assign bus.tx_ready = tx_ready_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.rx_data  = rx_data_q;
  assign rx_err       = rx_err_q;
  assign init_done    = init_done_q;

endmodule
